// File: rtl/mem_block_copier_pkg.sv
// rtl/mem_block_copier_pkg.sv - shared encodings and constants for the block copier
package mem_block_copier_pkg;

    localparam int DEFAULT_DATA_SIZE = 32;
    localparam int WORD_BYTES        = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } copier_state_t;

    // Byte address forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/mem_block_copier_if.sv
// rtl/mem_block_copier_if.sv - memory bus between the copier (master) and the Memory (slave)
interface mem_block_copier_if
    import mem_block_copier_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
);
    logic [31:0]          mem_address;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;
    logic                 mem_read;
    logic                 mem_write;

    modport master (
        output mem_address, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport slave (
        input  mem_address, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/mem_block_copier_addr_gen.sv
// rtl/mem_block_copier_addr_gen.sv - loadable 32-bit word pointer stepping by WORD_BYTES
module mem_block_copier_addr_gen
    import mem_block_copier_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_load_addr,
    input  logic        i_inc,
    output logic [31:0] o_ptr
);
    logic [31:0] r_ptr;

    // Plain 32-bit add: wraps 0xFFFFFFFC -> 0x00000000.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 32'd0;
        end else if (i_load) begin
            r_ptr <= i_load_addr;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 32'(WORD_BYTES);
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - bus initiator copying word_count words from src to dst, one read/write pair per word
module mem_block_copier
    import mem_block_copier_pkg::*;
#(
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int COUNT_WIDTH = 16
)(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [31:0]            i_src_addr,
    input  logic [31:0]            i_dst_addr,
    input  logic [COUNT_WIDTH-1:0] i_word_count,
    output logic                   o_busy,
    output logic                   o_done,
    mem_block_copier_if.master     bus
);
    copier_state_t          r_state;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [DATA_SIZE-1:0]   r_buf;
    logic [31:0]            r_mem_address;
    logic                   r_mem_read;
    logic                   r_mem_write;
    logic                   r_busy;
    logic                   r_done;

    logic        w_accept;
    logic [31:0] w_src_aligned;
    logic [31:0] w_dst_aligned;
    logic [31:0] w_src_ptr;
    logic [31:0] w_dst_ptr;

    assign w_accept      = (r_state == ST_IDLE) && i_start;
    assign w_src_aligned = word_align(i_src_addr);
    assign w_dst_aligned = word_align(i_dst_addr);

    mem_block_copier_addr_gen u_src_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_accept),
        .i_load_addr (w_src_aligned),
        .i_inc       (r_state == ST_READ),
        .o_ptr       (w_src_ptr)
    );

    mem_block_copier_addr_gen u_dst_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_accept),
        .i_load_addr (w_dst_aligned),
        .i_inc       (r_state == ST_WRITE),
        .o_ptr       (w_dst_ptr)
    );

    // Outputs are registered with the state they belong to, so each transition also sets the next state's outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_buf         <= '0;
            r_mem_address <= 32'd0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_remaining <= i_word_count;
                        if (i_word_count == '0) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= ST_READ;
                            r_busy        <= 1'b1;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= w_src_aligned;
                        end
                    end
                end
                ST_READ: begin
                    r_buf         <= bus.mem_rdata;
                    r_state       <= ST_WRITE;
                    r_mem_read    <= 1'b0;
                    r_mem_write   <= 1'b1;
                    r_mem_address <= w_dst_ptr;
                end
                ST_WRITE: begin
                    r_remaining <= r_remaining - 1'b1;
                    r_mem_write <= 1'b0;
                    if (r_remaining == COUNT_WIDTH'(1)) begin
                        r_state <= ST_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state       <= ST_READ;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= w_src_ptr;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_wdata   = r_buf;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
endmodule
